// File: rtl/control_sequencer.sv
// Fixed 6-T-state fetch/execute sequencer driving the shared-bus strobes of the 8-bit CPU.
// Optional feature macro: CTRL_JMP_EN (opcode 0011 becomes JMP, driving pc_ie in T3).
module control_sequencer #(
    parameter int OPC_W    = 4,
    parameter int N_TSTATE = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OPC_W-1:0] opcode,
    output logic [2:0]       tstate,
    output logic             halted,
    output logic             pc_oe,
    output logic             pc_step,
    output logic             pc_ie,
    output logic             mar_ie,
    output logic             ram_oe,
    output logic             ir_ie,
    output logic             ir_oe,
    output logic             a_ie,
    output logic             a_oe,
    output logic             b_ie,
    output logic             alu_oe,
    output logic             alu_sub,
    output logic             out_ie
);

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4,
        T5 = 3'd5
    } tstate_e;

    localparam logic [OPC_W-1:0] OP_LDA = OPC_W'(4'b0000);
    localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(4'b0001);
    localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(4'b0010);
    localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(4'b0011);
    localparam logic [OPC_W-1:0] OP_OUT = OPC_W'(4'b1110);
    localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(4'b1111);
    localparam tstate_e T_LAST = tstate_e'(N_TSTATE - 1);

    tstate_e tstate_q, tstate_d;
    logic    halted_q, halted_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tstate_q <= T0;
            halted_q <= 1'b0;
        end else begin
            tstate_q <= tstate_d;
            halted_q <= halted_d;
        end
    end

    // HLT freezes the counter at T3 on the same edge that sets halted.
    always_comb begin
        tstate_d = tstate_q;
        halted_d = halted_q;
        if (!halted_q) begin
            if (tstate_q == T3 && opcode == OP_HLT) begin
                halted_d = 1'b1;
            end else if (tstate_q == T_LAST) begin
                tstate_d = T0;
            end else begin
                tstate_d = tstate_e'(tstate_q + 3'd1);
            end
        end
    end

    always_comb begin
        pc_oe   = 1'b0;
        pc_step = 1'b0;
        pc_ie   = 1'b0;
        mar_ie  = 1'b0;
        ram_oe  = 1'b0;
        ir_ie   = 1'b0;
        ir_oe   = 1'b0;
        a_ie    = 1'b0;
        a_oe    = 1'b0;
        b_ie    = 1'b0;
        alu_oe  = 1'b0;
        alu_sub = 1'b0;
        out_ie  = 1'b0;
        // Gating on rst directly makes a mid-instruction reset silence the bus at once.
        if (!rst && !halted_q) begin
            case (tstate_q)
                T0: begin
                    pc_oe  = 1'b1;
                    mar_ie = 1'b1;
                end
                T1: pc_step = 1'b1;
                T2: begin
                    ram_oe = 1'b1;
                    ir_ie  = 1'b1;
                end
                T3: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            ir_oe  = 1'b1;
                            mar_ie = 1'b1;
                        end
`ifdef CTRL_JMP_EN
                        OP_JMP: begin
                            ir_oe = 1'b1;
                            pc_ie = 1'b1;
                        end
`endif
                        OP_OUT: begin
                            a_oe   = 1'b1;
                            out_ie = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    case (opcode)
                        OP_LDA: begin
                            ram_oe = 1'b1;
                            a_ie   = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ram_oe = 1'b1;
                            b_ie   = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T5: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        alu_oe  = 1'b1;
                        a_ie    = 1'b1;
                        alu_sub = (opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    assign tstate = tstate_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: instruction-level reference model checked every negedge, plus literal pins.
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] opcode;
    logic [2:0] tstate;
    logic       halted;
    logic pc_oe, pc_step, pc_ie, mar_ie, ram_oe, ir_ie, ir_oe;
    logic a_ie, a_oe, b_ie, alu_oe, alu_sub, out_ie;

    control_sequencer #(.OPC_W(4), .N_TSTATE(6)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .tstate(tstate), .halted(halted),
        .pc_oe(pc_oe), .pc_step(pc_step), .pc_ie(pc_ie), .mar_ie(mar_ie),
        .ram_oe(ram_oe), .ir_ie(ir_ie), .ir_oe(ir_oe), .a_ie(a_ie), .a_oe(a_oe),
        .b_ie(b_ie), .alu_oe(alu_oe), .alu_sub(alu_sub), .out_ie(out_ie)
    );

    always #5 clk = ~clk;

    localparam logic [12:0] S_PC_OE   = 13'h1000;
    localparam logic [12:0] S_PC_STEP = 13'h0800;
    localparam logic [12:0] S_PC_IE   = 13'h0400;
    localparam logic [12:0] S_MAR_IE  = 13'h0200;
    localparam logic [12:0] S_RAM_OE  = 13'h0100;
    localparam logic [12:0] S_IR_IE   = 13'h0080;
    localparam logic [12:0] S_IR_OE   = 13'h0040;
    localparam logic [12:0] S_A_IE    = 13'h0020;
    localparam logic [12:0] S_A_OE    = 13'h0010;
    localparam logic [12:0] S_B_IE    = 13'h0008;
    localparam logic [12:0] S_ALU_OE  = 13'h0004;
    localparam logic [12:0] S_ALU_SUB = 13'h0002;
    localparam logic [12:0] S_OUT_IE  = 13'h0001;

    int tests_run = 0;
    int tests_failed = 0;
    int step_count = 0;

    logic [12:0] strobes;
    assign strobes = {pc_oe, pc_step, pc_ie, mar_ie, ram_oe, ir_ie, ir_oe,
                      a_ie, a_oe, b_ie, alu_oe, alu_sub, out_ie};

    // Reference: which registers talk on which T-state for a given instruction.
    function automatic logic [12:0] micro(input int t, input int opc);
        if (t == 0) return S_PC_OE | S_MAR_IE;
        if (t == 1) return S_PC_STEP;
        if (t == 2) return S_RAM_OE | S_IR_IE;
        case (opc)
            0: return (t == 3) ? (S_IR_OE | S_MAR_IE) : (t == 4) ? (S_RAM_OE | S_A_IE) : 13'h0;
            1: return (t == 3) ? (S_IR_OE | S_MAR_IE) : (t == 4) ? (S_RAM_OE | S_B_IE)
                                                      : (S_ALU_OE | S_A_IE);
            2: return (t == 3) ? (S_IR_OE | S_MAR_IE) : (t == 4) ? (S_RAM_OE | S_B_IE)
                                                      : (S_ALU_OE | S_A_IE | S_ALU_SUB);
`ifdef CTRL_JMP_EN
            3: return (t == 3) ? (S_IR_OE | S_PC_IE) : 13'h0;
`endif
            14: return (t == 3) ? (S_A_OE | S_OUT_IE) : 13'h0;
            default: return 13'h0;
        endcase
    endfunction

    // Model: position within the instruction counts clocks since reset, until HLT's T3 edge.
    int m_t = 0;
    bit m_h = 1'b0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_t <= 0;
            m_h <= 1'b0;
        end else if (!m_h) begin
            if (m_t == 3 && opcode == 4'hF) m_h <= 1'b1;
            else m_t <= (m_t + 1) % 6;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [12:0] exp_s;
        exp_s = (rst || m_h) ? 13'h0 : micro(m_t, int'(opcode));
        check("model_tstate", 32'(tstate), 32'(m_t));
        check("model_halted", 32'(halted), 32'(m_h));
        check("model_strobes", 32'(strobes), 32'(exp_s));
        check("bus_onehot", 32'($countones({pc_oe, ram_oe, ir_oe, a_oe, alu_oe}) <= 1), 32'd1);
        if (pc_step === 1'b1) step_count++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        tests_failed++;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "timeout");
    end

    task automatic start_after_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic run_instr(input logic [3:0] opc);
        opcode = opc;
        repeat (6) @(posedge clk);
        #1;
    endtask

    // Walks one instruction comparing each T-state against hand-written literals.
    task automatic run_lit(input string name, input logic [3:0] opc,
                           input logic [12:0] e0, input logic [12:0] e1, input logic [12:0] e2,
                           input logic [12:0] e3, input logic [12:0] e4, input logic [12:0] e5);
        logic [12:0] e [6];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3; e[4] = e4; e[5] = e5;
        opcode = opc;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            check({name, "_lit_strobes"}, 32'(strobes), 32'(e[t]));
            check({name, "_lit_tstate"}, 32'(tstate), t);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int steps0;
        rst = 1'b1;
        opcode = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_halted", 32'(halted), 32'd0);
        @(posedge clk); #1;

        start_after_reset();
        run_lit("lda", 4'h0, S_PC_OE | S_MAR_IE, S_PC_STEP, S_RAM_OE | S_IR_IE,
                S_IR_OE | S_MAR_IE, S_RAM_OE | S_A_IE, 13'h0);
        @(negedge clk);
        check("lda_wrap_tstate", 32'(tstate), 32'd0);
        @(posedge clk); #1;
        repeat (5) @(posedge clk);
        #1;

        run_lit("sub", 4'h2, S_PC_OE | S_MAR_IE, S_PC_STEP, S_RAM_OE | S_IR_IE,
                S_IR_OE | S_MAR_IE, S_RAM_OE | S_B_IE, S_ALU_OE | S_ALU_SUB | S_A_IE);
        run_lit("add", 4'h1, S_PC_OE | S_MAR_IE, S_PC_STEP, S_RAM_OE | S_IR_IE,
                S_IR_OE | S_MAR_IE, S_RAM_OE | S_B_IE, S_ALU_OE | S_A_IE);
        run_lit("out", 4'hE, S_PC_OE | S_MAR_IE, S_PC_STEP, S_RAM_OE | S_IR_IE,
                S_A_OE | S_OUT_IE, 13'h0, 13'h0);
`ifdef CTRL_JMP_EN
        run_lit("jmp", 4'h3, S_PC_OE | S_MAR_IE, S_PC_STEP, S_RAM_OE | S_IR_IE,
                S_IR_OE | S_PC_IE, 13'h0, 13'h0);
`else
        run_lit("nop3", 4'h3, S_PC_OE | S_MAR_IE, S_PC_STEP, S_RAM_OE | S_IR_IE,
                13'h0, 13'h0, 13'h0);
`endif

        // HLT: frozen at T3, bus quiet, until reset.
        opcode = 4'hF;
        repeat (4) @(posedge clk);
        #1;
        check("hlt_halted", 32'(halted), 32'd1);
        check("hlt_tstate", 32'(tstate), 32'd3);
        repeat (20) @(posedge clk);
        #1;
        check("hlt_hold_tstate", 32'(tstate), 32'd3);
        check("hlt_hold_strobes", 32'(strobes), 32'd0);
        rst = 1'b1;
        #2;
        check("hlt_rst_halted", 32'(halted), 32'd0);
        check("hlt_rst_tstate", 32'(tstate), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        opcode = 4'h0;
        repeat (6) @(posedge clk);
        #1;

        // Reset mid-T4 of ADD, between edges.
        opcode = 4'h1;
        repeat (4) @(posedge clk);
        #2;
        check("midrst_pre_strobes", 32'(strobes), 32'(S_RAM_OE | S_B_IE));
        rst = 1'b1;
        #1;
        check("midrst_strobes", 32'(strobes), 32'd0);
        check("midrst_tstate", 32'(tstate), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_t0_strobes", 32'(strobes), 32'(S_PC_OE | S_MAR_IE));
        @(posedge clk); #1;
        repeat (5) @(posedge clk);
        #1;

        // Opcode sweep; HLT last so the other fifteen complete first.
        steps0 = step_count;
        for (int i = 0; i < 16; i++) run_instr(4'(i));
        check("sweep_pc_steps", 32'(step_count - steps0), 32'd16);
        check("sweep_halted", 32'(halted), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
